irrigation_countdown_timer: RTL and testbench

//   Countdown timer for irrigation runtime, MM:SS in BCD (max 39:59).

---
 rtl/irrigation_timer_pkg.sv | 40 ++++
 rtl/bcd_down_digit.sv | 41 ++++
 rtl/irrigation_countdown_timer.sv | 138 +++++++++++++
 tb/tb_irrigation_countdown_timer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_timer_pkg.sv
// Shared constants and helpers for the irrigation countdown timer:
// BCD digit widths and maxima, the two irrigation presets, and the
// preset validity / zero-count checks used by the timer top.
package irrigation_timer_pkg;

   localparam int MIN_D_W = 2;
   localparam int MIN_U_W = 4;
   localparam int SEC_D_W = 3;
   localparam int SEC_U_W = 4;

   localparam int MIN_D_MAX = 3;
   localparam int MIN_U_MAX = 9;
   localparam int SEC_D_MAX = 5;
   localparam int SEC_U_MAX = 9;

   typedef struct packed {
      logic [MIN_D_W-1:0] min_d;
      logic [MIN_U_W-1:0] min_u;
      logic [SEC_D_W-1:0] sec_d;
      logic [SEC_U_W-1:0] sec_u;
   } bcd_time_t;

   localparam bcd_time_t SPRINKLER_PRESET = '{min_d: 2'd1, min_u: 4'd5, sec_d: 3'd0, sec_u: 4'd0};
   localparam bcd_time_t DRIPPER_PRESET   = '{min_d: 2'd3, min_u: 4'd0, sec_d: 3'd0, sec_u: 4'd0};

   // Tens of minutes is 2 bits wide so it can never exceed its maximum.
   function automatic logic preset_is_invalid(input logic [MIN_U_W-1:0] min_u,
                                              input logic [SEC_D_W-1:0] sec_d);
      return (min_u > MIN_U_W'(MIN_U_MAX)) || (sec_d > SEC_D_W'(SEC_D_MAX));
   endfunction

   function automatic logic time_is_zero(input bcd_time_t t);
      return (t == '0);
   endfunction

   function automatic logic time_is_one_sec(input bcd_time_t t);
      return (t.min_d == '0) && (t.min_u == '0) && (t.sec_d == '0) && (t.sec_u == SEC_U_W'(1));
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit. Loads synchronously, decrements when a
// borrow arrives from the lower digit and wraps from 0 to MAX, passing
// the borrow on to the next higher digit.
module bcd_down_digit
   import irrigation_timer_pkg::*;
#(
   parameter int W   = SEC_U_W,
   parameter int MAX = SEC_U_MAX
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         borrow_in,
   output logic [W-1:0] value,
   output logic         borrow_out
);

   localparam logic [W-1:0] LP_MAX = W'(MAX);

   logic [W-1:0] r_value;

   // Digit register: load beats borrow, borrow at zero wraps to MAX.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_value <= '0;
      end else if (load) begin
         r_value <= load_val;
      end else if (borrow_in) begin
         if (r_value == '0) begin
            r_value <= LP_MAX;
         end else begin
            r_value <= r_value - W'(1);
         end
      end
   end

   assign value      = r_value;
   assign borrow_out = borrow_in & (r_value == '0);

endmodule

// File: rtl/irrigation_countdown_timer.sv
// MM:SS BCD countdown for irrigation runtime. A prescaler turns clock
// cycles into one-second ticks; the tick feeds a chain of four BCD
// digits. The count stops at 00:00 and signals expiry with a single
// registered pulse. Invalid presets load as 00:00 and raise a sticky
// flag until the next load.
module irrigation_countdown_timer
   import irrigation_timer_pkg::*;
#(
   parameter int TICKS_PER_SECOND = 50_000_000,
   parameter int PRESCALE_W       = 26
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               load,
   input  logic               enable,
   input  logic [MIN_D_W-1:0] minutes_d_preset,
   input  logic [MIN_U_W-1:0] minutes_u_preset,
   input  logic [SEC_D_W-1:0] seconds_d_preset,
   output logic [MIN_D_W-1:0] minutes_d,
   output logic [MIN_U_W-1:0] minutes_u,
   output logic [SEC_D_W-1:0] seconds_d,
   output logic [SEC_U_W-1:0] seconds_u,
   output logic               expired,
   output logic               preset_invalid
);

   localparam logic [PRESCALE_W-1:0] LP_TC = PRESCALE_W'(TICKS_PER_SECOND - 1);

   logic [PRESCALE_W-1:0] r_prescale;
   logic                  r_expired;
   logic                  r_preset_invalid;

   logic                  w_preset_bad;
   bcd_time_t             w_load_val;
   bcd_time_t             w_count;
   logic                  w_count_zero;
   logic                  w_one_left;
   logic                  w_run;
   logic                  w_sec_tick;
   logic                  w_b_su;
   logic                  w_b_sd;
   logic                  w_b_mu;
   logic                  w_b_md;

   assign w_preset_bad = preset_is_invalid(minutes_u_preset, seconds_d_preset);

   // A rejected preset loads as 00:00 so the count never holds a non-BCD digit.
   always_comb begin
      w_load_val = '0;
      if (!w_preset_bad) begin
         w_load_val.min_d = minutes_d_preset;
         w_load_val.min_u = minutes_u_preset;
         w_load_val.sec_d = seconds_d_preset;
      end
   end

   assign w_count      = '{min_d: minutes_d, min_u: minutes_u, sec_d: seconds_d, sec_u: seconds_u};
   assign w_count_zero = time_is_zero(w_count);
   assign w_one_left   = time_is_one_sec(w_count);

   // The prescaler only runs while counting, so 00:00 freezes it too.
   assign w_run      = enable & ~load & ~w_count_zero;
   assign w_sec_tick = w_run & (r_prescale == LP_TC);

   // Prescaler: cleared by load, frozen (not cleared) when enable drops.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_prescale <= '0;
      end else if (load) begin
         r_prescale <= '0;
      end else if (w_run) begin
         if (r_prescale == LP_TC) begin
            r_prescale <= '0;
         end else begin
            r_prescale <= r_prescale + PRESCALE_W'(1);
         end
      end
   end

   bcd_down_digit #(.W(SEC_U_W), .MAX(SEC_U_MAX)) u_sec_u (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .load_val   (w_load_val.sec_u),
      .borrow_in  (w_sec_tick),
      .value      (seconds_u),
      .borrow_out (w_b_su)
   );

   bcd_down_digit #(.W(SEC_D_W), .MAX(SEC_D_MAX)) u_sec_d (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .load_val   (w_load_val.sec_d),
      .borrow_in  (w_b_su),
      .value      (seconds_d),
      .borrow_out (w_b_sd)
   );

   bcd_down_digit #(.W(MIN_U_W), .MAX(MIN_U_MAX)) u_min_u (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .load_val   (w_load_val.min_u),
      .borrow_in  (w_b_sd),
      .value      (minutes_u),
      .borrow_out (w_b_mu)
   );

   bcd_down_digit #(.W(MIN_D_W), .MAX(MIN_D_MAX)) u_min_d (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .load_val   (w_load_val.min_d),
      .borrow_in  (w_b_mu),
      .value      (minutes_d),
      .borrow_out (w_b_md)
   );

   // Expiry pulse and preset flag. A borrow out of the tens of minutes
   // cannot occur (00:00 stops the tick); masking with it guarantees a
   // wrap could never be mistaken for expiry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_expired        <= 1'b0;
         r_preset_invalid <= 1'b0;
      end else if (load) begin
         r_expired        <= 1'b0;
         r_preset_invalid <= w_preset_bad;
      end else begin
         r_expired        <= w_sec_tick & w_one_left & ~w_b_md;
      end
   end

   assign expired        = r_expired;
   assign preset_invalid = r_preset_invalid;

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// Bench for irrigation_countdown_timer with a 4-cycle second. Each
// clock step pushes the reference model's expectation onto a scoreboard
// queue and pops it after the edge; table records also carry
// hand-derived expected values checked at the end of each record.
module tb_irrigation_countdown_timer;
   import irrigation_timer_pkg::*;

   localparam int TPS = 4;

   logic       clock;
   logic       reset_n;
   logic       load;
   logic       enable;
   logic [1:0] minutes_d_preset;
   logic [3:0] minutes_u_preset;
   logic [2:0] seconds_d_preset;
   logic [1:0] minutes_d;
   logic [3:0] minutes_u;
   logic [2:0] seconds_d;
   logic [3:0] seconds_u;
   logic       expired;
   logic       preset_invalid;

   irrigation_countdown_timer #(.TICKS_PER_SECOND(TPS), .PRESCALE_W(2)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .load             (load),
      .enable           (enable),
      .minutes_d_preset (minutes_d_preset),
      .minutes_u_preset (minutes_u_preset),
      .seconds_d_preset (seconds_d_preset),
      .minutes_d        (minutes_d),
      .minutes_u        (minutes_u),
      .seconds_d        (seconds_d),
      .seconds_u        (seconds_u),
      .expired          (expired),
      .preset_invalid   (preset_invalid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] md;
      logic [3:0] mu;
      logic [2:0] sd;
      logic [3:0] su;
      logic       ex;
      logic       inv;
   } exp_t;

   typedef struct {
      string      name;
      logic       ld;
      logic       en;
      logic [1:0] pmd;
      logic [3:0] pmu;
      logic [2:0] psd;
      int         ncyc;
      exp_t       e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   int n_checks = 0;
   int n_errors = 0;

   int   m_tot = 0;
   int   m_pre = 0;
   logic m_exp = 1'b0;
   logic m_inv = 1'b0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, req);
      end
   endtask

   task automatic chk_all(input string nm, input exp_t e);
      chk({nm, ".min_d"}, 8'(minutes_d), 8'(e.md));
      chk({nm, ".min_u"}, 8'(minutes_u), 8'(e.mu));
      chk({nm, ".sec_d"}, 8'(seconds_d), 8'(e.sd));
      chk({nm, ".sec_u"}, 8'(seconds_u), 8'(e.su));
      chk({nm, ".expired"}, 8'(expired), 8'(e.ex));
      chk({nm, ".invalid"}, 8'(preset_invalid), 8'(e.inv));
   endtask

   function automatic exp_t mk(input int md, mu, sd, su, input logic ex, inv);
      exp_t e;
      e.md = 2'(md); e.mu = 4'(mu); e.sd = 3'(sd); e.su = 4'(su);
      e.ex = ex; e.inv = inv;
      return e;
   endfunction

   function automatic vec_t v(input string nm, input logic ld, en, input int pmd, pmu, psd,
                              input int n, input int md, mu, sd, su, input logic ex, inv);
      vec_t r;
      r.name = nm; r.ld = ld; r.en = en;
      r.pmd = 2'(pmd); r.pmu = 4'(pmu); r.psd = 3'(psd);
      r.ncyc = n;
      r.e = mk(md, mu, sd, su, ex, inv);
      return r;
   endfunction

   // Model works on a plain seconds total, independent of the BCD chain.
   task automatic step(input logic ld, en, input logic [1:0] pmd, input logic [3:0] pmu,
                       input logic [2:0] psd);
      exp_t e;
      load = ld; enable = en;
      minutes_d_preset = pmd; minutes_u_preset = pmu; seconds_d_preset = psd;
      if (ld) begin
         m_inv = (pmu > 4'd9) || (psd > 3'd5);
         m_tot = m_inv ? 0 : (int'(pmd) * 10 + int'(pmu)) * 60 + int'(psd) * 10;
         m_pre = 0;
         m_exp = 1'b0;
      end else begin
         m_exp = 1'b0;
         if (en && m_tot != 0) begin
            if (m_pre == TPS - 1) begin
               m_pre = 0;
               m_tot--;
               m_exp = (m_tot == 0);
            end else begin
               m_pre++;
            end
         end
      end
      sb.push_back(mk(m_tot / 600, (m_tot / 60) % 10, (m_tot % 60) / 10, m_tot % 10, m_exp, m_inv));
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk_all("sb", e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      vecs.push_back(v("ld1500",      1, 0, 1, 5, 0,   1,  1, 5, 0, 0, 0, 0));
      vecs.push_back(v("pre3",        0, 1, 0, 0, 0,   3,  1, 5, 0, 0, 0, 0));
      vecs.push_back(v("dec1459",     0, 1, 0, 0, 0,   1,  1, 4, 5, 9, 0, 0));
      vecs.push_back(v("to1450",      0, 1, 0, 0, 0,  36,  1, 4, 5, 0, 0, 0));
      vecs.push_back(v("carry1449",   0, 1, 0, 0, 0,   4,  1, 4, 4, 9, 0, 0));
      vecs.push_back(v("prewrap",     0, 1, 0, 0, 0,   3,  1, 4, 4, 9, 0, 0));
      vecs.push_back(v("loadonwrap",  1, 1, 2, 0, 0,   1,  2, 0, 0, 0, 0, 0));
      vecs.push_back(v("after_load",  0, 1, 0, 0, 0,   4,  1, 9, 5, 9, 0, 0));
      vecs.push_back(v("ld0000",      1, 1, 0, 0, 0,   1,  0, 0, 0, 0, 0, 0));
      vecs.push_back(v("zerohold",    0, 1, 0, 0, 0,   8,  0, 0, 0, 0, 0, 0));
      vecs.push_back(v("ld0100",      1, 1, 0, 1, 0,   1,  0, 1, 0, 0, 0, 0));
      vecs.push_back(v("to0001",      0, 1, 0, 0, 0, 236,  0, 0, 0, 1, 0, 0));
      vecs.push_back(v("hold0001",    0, 1, 0, 0, 0,   3,  0, 0, 0, 1, 0, 0));
      vecs.push_back(v("expire",      0, 1, 0, 0, 0,   1,  0, 0, 0, 0, 1, 0));
      vecs.push_back(v("expire_off",  0, 1, 0, 0, 0,   1,  0, 0, 0, 0, 0, 0));
      vecs.push_back(v("hold20s",     0, 1, 0, 0, 0,  80,  0, 0, 0, 0, 0, 0));
      vecs.push_back(v("ld3000",      1, 1, 3, 0, 0,   1,  3, 0, 0, 0, 0, 0));
      vecs.push_back(v("run2",        0, 1, 0, 0, 0,   2,  3, 0, 0, 0, 0, 0));
      vecs.push_back(v("pause7",      0, 0, 0, 0, 0,   7,  3, 0, 0, 0, 0, 0));
      vecs.push_back(v("resume1",     0, 1, 0, 0, 0,   1,  3, 0, 0, 0, 0, 0));
      vecs.push_back(v("resume2",     0, 1, 0, 0, 0,   1,  2, 9, 5, 9, 0, 0));
      vecs.push_back(v("next_sec",    0, 1, 0, 0, 0,   4,  2, 9, 5, 8, 0, 0));
      vecs.push_back(v("ld_bad_mu",   1, 1, 0, 12, 0,  1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(v("bad_hold",    0, 1, 0, 0, 0,   8,  0, 0, 0, 0, 0, 1));
      vecs.push_back(v("ld_bad_sd",   1, 1, 0, 5, 6,   1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(v("ld2240",      1, 0, 2, 2, 4,   1,  2, 2, 4, 0, 0, 0));
      vecs.push_back(v("to2237",      0, 1, 0, 0, 0,  12,  2, 2, 3, 7, 0, 0));
      vecs.push_back(v("mid2237",     0, 1, 0, 0, 0,   2,  2, 2, 3, 7, 0, 0));

      reset_n = 1'b0; load = 1'b0; enable = 1'b0;
      minutes_d_preset = '0; minutes_u_preset = '0; seconds_d_preset = '0;
      @(posedge clock);
      #1;
      chk_all("reset", mk(0, 0, 0, 0, 0, 0));
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         for (int c = 0; c < vecs[i].ncyc; c++) begin
            step(vecs[i].ld, vecs[i].en, vecs[i].pmd, vecs[i].pmu, vecs[i].psd);
         end
         chk_all(vecs[i].name, vecs[i].e);
      end

      // Asynchronous reset between edges while counting at 22:37.
      #2;
      reset_n = 1'b0;
      #1;
      chk_all("async_rst", mk(0, 0, 0, 0, 0, 0));
      m_tot = 0; m_pre = 0; m_exp = 1'b0; m_inv = 1'b0;
      @(posedge clock);
      #1;
      chk_all("rst_held", mk(0, 0, 0, 0, 0, 0));
      reset_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step(1'b0, 1'b1, 2'd0, 4'd0, 3'd0);
      end
      chk_all("post_rst", mk(0, 0, 0, 0, 0, 0));

      // Sprinkler preset from the package loads and starts counting.
      step(1'b1, 1'b1, SPRINKLER_PRESET.min_d, SPRINKLER_PRESET.min_u, SPRINKLER_PRESET.sec_d);
      for (int c = 0; c < TPS; c++) begin
         step(1'b0, 1'b1, 2'd0, 4'd0, 3'd0);
      end
      chk_all("sprinkler", mk(1, 4, 5, 9, 0, 0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
